pulse_train_gen: RTL
====================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of phase-length fields.
REQ-002 SHALL have parameter NUM_W, default 8, width of pulse-count field.
REQ-003 SHALL have port clk50m  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a train.
REQ-006 SHALL have port abort  input  1  single-cycle request to stop a train.
REQ-007 SHALL have port high_cycles  input  CNT_W  high-phase length in clocks.
REQ-008 SHALL have port low_cycles  input  CNT_W  low-phase length in clocks.
REQ-009 SHALL have port n_pulses  input  NUM_W  pulses per train; 0 = continuous.
REQ-010 SHALL have port pulse_out  output  1  generated waveform, registered.
REQ-011 SHALL have port busy  output  1  high while a train is in progress.
REQ-012 SHALL have port done  output  1  one-cycle strobe on normal train completion.

Function
REQ-013 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-014 SHALL, in IDLE with start=1 and abort=0, latch high_cycles, low_cycles and n_pulses and enter HIGH on the next edge.
REQ-015 SHALL drive pulse_out=1 exactly in HIGH and 0 in IDLE and LOW, so pulse_out rises one clock after start is sampled.
REQ-016 SHALL hold HIGH for max(high_cycles,1) clocks and LOW for max(low_cycles,1) clocks; a latched value of 0 is treated as 1.
REQ-017 SHALL use a down-counter of CNT_W bits per phase; the counter never wraps.
REQ-018 SHALL decrement a NUM_W-bit remaining-pulse counter on each HIGH->LOW transition when n_pulses is nonzero.
REQ-019 SHALL, at the end of LOW with the remaining count at 0 and n_pulses nonzero, return to IDLE and assert done for that single cycle.
REQ-020 SHALL, at the end of LOW otherwise, re-enter HIGH with no idle gap.
REQ-021 SHALL, with n_pulses=0, repeat HIGH/LOW until abort and never assert done.
REQ-022 SHALL assert busy in HIGH and LOW; busy and done SHALL be registered and change on the same edge as the state.
REQ-023 SHALL ignore start while busy=1; input-field changes while busy SHALL NOT affect the running train.
REQ-024 SHALL, on abort=1 in HIGH or LOW, enter IDLE on the next edge with pulse_out=0, busy=0 and done=0.
REQ-025 SHALL let abort win when start and abort are both 1 in IDLE: no train starts.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, pulse_out=0, busy=0, done=0 and all counters to 0, asynchronously.
REQ-027 SHALL, when reset is asserted mid-train, discard the train with no done strobe, and require a new start after release.

Configuration
REQ-028 SHALL, with macro PULSE_TRAIN_GEN_SYNC_EN defined, pass start and abort through a two-flop synchronizer (reset value 0) and add two clocks of latency from input to FSM.
REQ-029 SHALL, without PULSE_TRAIN_GEN_SYNC_EN, sample start and abort directly as synchronous inputs; all latencies are then as stated in REQ-014 and REQ-024.

Structure
REQ-030 SHALL place the state enum typedef (ptg_state_t) and the default widths (PTG_CNT_W=16, PTG_NUM_W=8) in shared package ptg_pkg.
REQ-031 SHALL implement the optional synchronizer as sub-module ptg_sync2, instantiated only under PULSE_TRAIN_GEN_SYNC_EN.

Verification (macro undefined unless stated)
REQ-032 SHALL cover: start with high=3, low=2, n=2 -> pulse_out 1,1,1,0,0,1,1,1,0,0 from cycle +1; done on the 10th cycle; busy low on the 11th.
REQ-033 SHALL cover: start with high=0, low=0, n=1 -> one 1-clock high and one 1-clock low; done on cycle +2.
REQ-034 SHALL cover: n=0, high=2, low=2; abort after 9 clocks -> continuous 2/2 waveform; pulse_out=0 and busy=0 on the next edge; done never asserted.
REQ-035 SHALL cover: start pulsed again mid-train, with fields changed to high=5 -> waveform unchanged and a single done.
REQ-036 SHALL cover: start and abort in the same cycle in IDLE -> busy stays 0; and rst_n low mid-HIGH -> pulse_out=0 immediately, no done.
REQ-037 SHALL cover: with PULSE_TRAIN_GEN_SYNC_EN defined, rerun REQ-032 -> identical waveform shifted by exactly 2 clocks.

Source files
------------

// File: rtl/ptg_pkg.sv
// Shared types and default widths for the pulse train generator.
package ptg_pkg;

    localparam int PTG_CNT_W = 16;
    localparam int PTG_NUM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ptg_state_t;

endpackage

// File: rtl/ptg_sync2.sv
// Two-flop synchronizer for asynchronous control requests; flops reset to 0.
module ptg_sync2 #(
    parameter int W = 1
) (
    input  logic         clk50m,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // two-stage capture of the incoming requests
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator (IDLE/HIGH/LOW FSM, registered outputs).
// Define PULSE_TRAIN_GEN_SYNC_EN to pass start/abort through ptg_sync2.
module pulse_train_gen
    import ptg_pkg::*;
#(
    parameter int CNT_W = PTG_CNT_W,
    parameter int NUM_W = PTG_NUM_W
) (
    input  logic             clk50m,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    input  logic [NUM_W-1:0] n_pulses,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_TWO = {{(CNT_W-2){1'b0}}, 2'b10};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    // A zero phase length behaves as a single clock.
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        if (v == '0) begin
            return CNT_ONE;
        end else begin
            return v;
        end
    endfunction

    ptg_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] high_lat_r;
    logic [CNT_W-1:0] low_lat_r;
    logic [NUM_W-1:0] n_lat_r;
    logic [NUM_W-1:0] rem_r;
    logic             pulse_out_r;
    logic             busy_r;
    logic             done_r;

    logic             start_s;
    logic             abort_s;
    logic             counted_s;
    logic [NUM_W-1:0] rem_dec_s;
    logic [CNT_W-1:0] high_len_s;
    logic [CNT_W-1:0] low_len_s;
    logic [CNT_W-1:0] start_len_s;

`ifdef PULSE_TRAIN_GEN_SYNC_EN
    ptg_sync2 #(.W(2)) u_sync (
        .clk50m (clk50m),
        .rst_n  (rst_n),
        .d      ({start, abort}),
        .q      ({start_s, abort_s})
    );
`else
    assign start_s = start;
    assign abort_s = abort;
`endif

    assign counted_s   = (n_lat_r != '0);
    assign rem_dec_s   = counted_s ? (rem_r - NUM_ONE) : rem_r;
    assign high_len_s  = at_least_one(high_lat_r);
    assign low_len_s   = at_least_one(low_lat_r);
    assign start_len_s = at_least_one(high_cycles);

    // FSM; done is raised on entry to the final LOW clock of a counted train
    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            high_lat_r  <= '0;
            low_lat_r   <= '0;
            n_lat_r     <= '0;
            rem_r       <= '0;
            pulse_out_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start_s && !abort_s) begin
                        high_lat_r  <= high_cycles;
                        low_lat_r   <= low_cycles;
                        n_lat_r     <= n_pulses;
                        rem_r       <= n_pulses;
                        cnt_r       <= start_len_s;
                        state_r     <= HIGH;
                        pulse_out_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        pulse_out_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                HIGH: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        pulse_out_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end else if (cnt_r == CNT_ONE) begin
                        state_r     <= LOW;
                        cnt_r       <= low_len_s;
                        rem_r       <= rem_dec_s;
                        pulse_out_r <= 1'b0;
                        done_r      <= counted_s && (rem_dec_s == '0) && (low_len_s == CNT_ONE);
                    end else begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        done_r <= 1'b0;
                    end
                end
                LOW: begin
                    if (abort_s) begin
                        state_r     <= IDLE;
                        cnt_r       <= '0;
                        pulse_out_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b0;
                    end else if (cnt_r == CNT_ONE) begin
                        done_r <= 1'b0;
                        if (counted_s && (rem_r == '0)) begin
                            state_r     <= IDLE;
                            cnt_r       <= '0;
                            pulse_out_r <= 1'b0;
                            busy_r      <= 1'b0;
                        end else begin
                            state_r     <= HIGH;
                            cnt_r       <= high_len_s;
                            pulse_out_r <= 1'b1;
                        end
                    end else begin
                        cnt_r  <= cnt_r - CNT_ONE;
                        done_r <= counted_s && (rem_r == '0) && (cnt_r == CNT_TWO);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    pulse_out_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
